// File: rtl/key_decoder.sv
// PS/2 set-2 scan-code decoder producing per-player tank direction/fire controls.
// Tracks make/break per key, resolves direction conflicts, and pulses fire once per press.
module key_decoder #(
    parameter int unsigned PREFIX_TIMEOUT = 1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scan_valid,
    input  logic [7:0] scan_code,
    input  logic       game_on,
    output logic       up1,
    output logic       down1,
    output logic       left1,
    output logic       right1,
    output logic       fire1,
    output logic       up2,
    output logic       down2,
    output logic       left2,
    output logic       right2,
    output logic       fire2,
    output logic [9:0] held_keys
);

    localparam int unsigned CW = (PREFIX_TIMEOUT > 1) ? $clog2(PREFIX_TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(PREFIX_TIMEOUT - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_E0   = 2'd1;
    localparam logic [1:0] S_F0   = 2'd2;
    localparam logic [1:0] S_E0F0 = 2'd3;

    logic [1:0]    state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic [9:0]    held, held_next;
    logic [2:0]    last1, last1_next;   // {valid, dir}; dir 0=up 1=down 2=left 3=right
    logic [2:0]    last2, last2_next;
    logic [3:0]    dir1_q, dir2_q, dir1_next, dir2_next;
    logic          fire1_q, fire2_q, fire1_next, fire2_next;
    logic          dec_make, dec_brk, dec_ext;
    logic [4:0]    key;                 // {hit, index into held map}

    // Held-map index for a code; bit 4 clear means the code is not a game key.
    function automatic logic [4:0] map_key(input logic ext, input logic [7:0] code);
        logic [4:0] r;
        case ({ext, code})
            9'h01D:  r = {1'b1, 4'd0};
            9'h01B:  r = {1'b1, 4'd1};
            9'h01C:  r = {1'b1, 4'd2};
            9'h023:  r = {1'b1, 4'd3};
            9'h029:  r = {1'b1, 4'd4};
            9'h175:  r = {1'b1, 4'd5};
            9'h172:  r = {1'b1, 4'd6};
            9'h16B:  r = {1'b1, 4'd7};
            9'h174:  r = {1'b1, 4'd8};
            9'h05A:  r = {1'b1, 4'd9};
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic logic [1:0] prio(input logic [3:0] h);
        logic [1:0] r;
        if (h[0])      r = 2'd0;
        else if (h[1]) r = 2'd1;
        else if (h[2]) r = 2'd2;
        else           r = 2'd3;
        return r;
    endfunction

    // A fresh press takes over; releasing the tracked key falls back to fixed priority.
    function automatic logic [2:0] resolve(input logic [3:0] old_h, input logic [3:0] new_h,
                                           input logic [2:0] last);
        logic [3:0] pressed;
        logic [2:0] r;
        pressed = new_h & ~old_h;
        r = last;
        if (pressed != '0)
            r = {1'b1, prio(pressed)};
        else if (last[2] && !new_h[last[1:0]])
            r = (new_h != '0) ? {1'b1, prio(new_h)} : 3'b000;
        return r;
    endfunction

    function automatic logic [3:0] onehot(input logic en, input logic [2:0] last);
        logic [3:0] r;
        r = '0;
        if (en && last[2]) r[last[1:0]] = 1'b1;
        return r;
    endfunction

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        dec_make   = 1'b0;
        dec_brk    = 1'b0;
        dec_ext    = 1'b0;
        if (scan_valid) begin
            cnt_next = '0;
            case (state)
                S_IDLE: begin
                    if (scan_code == 8'hE0)      state_next = S_E0;
                    else if (scan_code == 8'hF0) state_next = S_F0;
                    else                         dec_make   = 1'b1;
                end
                S_E0: begin
                    if (scan_code == 8'hF0)      state_next = S_E0F0;
                    else if (scan_code != 8'hE0) begin
                        dec_make   = 1'b1;
                        dec_ext    = 1'b1;
                        state_next = S_IDLE;
                    end
                end
                S_F0: begin
                    if (scan_code == 8'hE0)      state_next = S_E0F0;
                    else if (scan_code != 8'hF0) begin
                        dec_brk    = 1'b1;
                        state_next = S_IDLE;
                    end
                end
                default: begin
                    if (scan_code != 8'hE0 && scan_code != 8'hF0) begin
                        dec_brk    = 1'b1;
                        dec_ext    = 1'b1;
                        state_next = S_IDLE;
                    end
                end
            endcase
        end else if (state == S_IDLE) begin
            cnt_next = '0;
        end else if (cnt == CNT_LAST) begin
            state_next = S_IDLE;
            cnt_next   = '0;
        end else begin
            cnt_next = cnt + 1'b1;
        end

        key       = map_key(dec_ext, scan_code);
        held_next = held;
        if (key[4] && dec_make) held_next[key[3:0]] = 1'b1;
        if (key[4] && dec_brk)  held_next[key[3:0]] = 1'b0;

        fire1_next = game_on && key[4] && dec_make && key[3:0] == 4'd4 && !held[4];
        fire2_next = game_on && key[4] && dec_make && key[3:0] == 4'd9 && !held[9];

        last1_next = resolve(held[3:0], held_next[3:0], last1);
        last2_next = resolve(held[8:5], held_next[8:5], last2);
        dir1_next  = onehot(game_on, last1_next);
        dir2_next  = onehot(game_on, last2_next);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            held    <= '0;
            last1   <= '0;
            last2   <= '0;
            dir1_q  <= '0;
            dir2_q  <= '0;
            fire1_q <= 1'b0;
            fire2_q <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            held    <= held_next;
            last1   <= last1_next;
            last2   <= last2_next;
            dir1_q  <= dir1_next;
            dir2_q  <= dir2_next;
            fire1_q <= fire1_next;
            fire2_q <= fire2_next;
        end
    end

    assign {right1, left1, down1, up1} = dir1_q;
    assign {right2, left2, down2, up2} = dir2_q;
    assign fire1     = fire1_q;
    assign fire2     = fire2_q;
    assign held_keys = held;

endmodule
